// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter/sequencer in front of a single-port
// synchronous memory (1-cycle registered read, write on rising edge).
//
// Requesters:
//   fetch (if_*) : read-only
//   data  (d_*)  : load (d_we=0) or store (d_we=1)
//
// Handshake (both requesters): the requester raises req together with its
// address/control/data and holds all of them stable until it sees a one-cycle
// ack pulse. A req still high in the cycle after the ack is a new
// transaction. The ack arrives two cycles after the request is first sampled
// in IDLE; read data is valid with the ack and held until the next read ack
// of that requester.
//
// Ports:
//   clock, clear          : clock, synchronous active-high reset
//   if_req/if_addr        : fetch request and address
//   if_ack/if_rdata       : fetch completion pulse and read data
//   d_req/d_we/d_addr/d_wdata : data request, direction, address, store data
//   d_ack/d_rdata         : data completion pulse and load data
//   ram_read/ram_write    : memory strobes (only in the grant cycle)
//   ram_address           : memory address
//   ram_data_in           : memory write data
//   ram_data_out          : memory read data (valid the cycle after the read)
//   busy                  : high while a transaction is in ACCESS or RESP
//   dbg_state             : current sequencer state (0=IDLE,1=ACCESS,2=RESP)
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  state_t            r_state;
  state_t            w_next_state;
  owner_t            r_owner;
  logic              r_last_is_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_grant_if;
  logic              w_grant_d;

  // Next-state and output decode. Strobes are only ever raised in the IDLE
  // grant cycle, so the memory sees at most one strobe per transaction.
  always_comb begin
    w_next_state = r_state;
    w_grant_if   = 1'b0;
    w_grant_d    = 1'b0;
    ram_read     = 1'b0;
    ram_write    = 1'b0;
    ram_address  = r_addr;
    ram_data_in  = d_wdata;
    if_ack       = 1'b0;
    d_ack        = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the requester that did not win last time goes first.
        w_grant_d  = d_req & (~if_req | ~r_last_is_data);
        w_grant_if = if_req & ~w_grant_d;
        if (w_grant_d) begin
          ram_address  = d_addr;
          ram_read     = ~d_we;
          ram_write    = d_we;
          w_next_state = S_ACCESS;
        end else if (w_grant_if) begin
          ram_address  = if_addr;
          ram_read     = 1'b1;
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_next_state = S_RESP;
      end
      S_RESP: begin
        if_ack       = (r_owner == OWN_FETCH);
        d_ack        = (r_owner == OWN_DATA);
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state        <= S_IDLE;
      r_owner        <= OWN_NONE;
      r_last_is_data <= 1'b0;
      r_addr         <= '0;
      r_we           <= 1'b0;
      r_if_rdata     <= '0;
      r_d_rdata      <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_owner        <= OWN_DATA;
            r_addr         <= d_addr;
            r_we           <= d_we;
            r_last_is_data <= 1'b1;
          end else if (w_grant_if) begin
            r_owner        <= OWN_FETCH;
            r_addr         <= if_addr;
            r_we           <= 1'b0;
            r_last_is_data <= 1'b0;
          end
        end
        S_ACCESS: begin
          // Memory output is valid here because the read was issued in the
          // grant cycle; a store leaves d_rdata untouched.
          if (r_owner == OWN_FETCH) begin
            r_if_rdata <= ram_data_out;
          end else if ((r_owner == OWN_DATA) && !r_we) begin
            r_d_rdata <= ram_data_out;
          end
        end
        S_RESP: begin
          r_owner <= OWN_NONE;
        end
        default: begin
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule
